// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: multi-port byte-serial memory access controller.
//
// Arbitrates NUM_PORTS requesters (port 0 highest priority) onto an 8-bit
// memory bus. A granted access of 1, 2 or 4 bytes is performed one byte per
// beat, each beat lasting BEAT_CYC cycles. Loads assemble bytes little-endian
// into rdata_o; stores drive wdata bytes onto mem_wdata with mem_wr high.
//
// Optional feature macro: MEM_CTRL_ALIGN_CHECK_EN
//   defined   -> misaligned requests complete immediately with err=1
//   undefined -> err is constant 0 and misaligned requests run byte-serially
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req, we         per-port request level (held until done) and store flag
//   size            per-port 2-bit size: 0=byte, 1=half, 2/3=word
//   addr_i, wdata_i per-port byte address and little-endian store data
//   cancel          per-port abort of the granted in-flight load
//   done, err       one-cycle completion and misalignment pulses
//   rdata_o         zero-extended load result, valid while done is high
//   busy            high whenever the controller is not idle
//   mem_wr, mem_addr, mem_wdata, mem_rdata   byte-wide memory bus
module mem_port_ctrl #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned BEAT_CYC  = 2,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [2*NUM_PORTS-1:0]      size,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr_i,
  input  logic [32*NUM_PORTS-1:0]     wdata_i,
  input  logic [NUM_PORTS-1:0]        cancel,
  output logic [NUM_PORTS-1:0]        done,
  output logic [NUM_PORTS-1:0]        err,
  output logic [31:0]                 rdata_o,
  output logic                        busy,
  output logic                        mem_wr,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [7:0]                  mem_wdata,
  input  logic [7:0]                  mem_rdata
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CYC_W  = 2;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Controller state and latched request
  state_e                 state_q, state_d;
  logic [PORT_W-1:0]      port_q, port_d;
  logic                   we_q, we_d;
  logic [1:0]             last_q, last_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [1:0]             byte_q, byte_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;

  // Registered outputs
  logic [NUM_PORTS-1:0]   done_q, done_d;
  logic [NUM_PORTS-1:0]   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   busy_q, busy_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [7:0]             mem_wdata_q, mem_wdata_d;

  // Fixed-priority grant candidate and its request fields
  logic                   gnt_vld_c;
  logic [PORT_W-1:0]      gnt_idx_c;
  logic                   gnt_we_c;
  logic [1:0]             gnt_size_c;
  logic [ADDR_W-1:0]      gnt_addr_c;
  logic [31:0]            gnt_wdata_c;
  logic [1:0]             gnt_last_c;
  logic                   misalign_c;
  logic [1:0]             nxt_byte_c;

  // Scan from the lowest priority upward so the lowest index wins
  always_comb begin
    gnt_vld_c   = 1'b0;
    gnt_idx_c   = '0;
    gnt_we_c    = 1'b0;
    gnt_size_c  = 2'd0;
    gnt_addr_c  = '0;
    gnt_wdata_c = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld_c   = 1'b1;
        gnt_idx_c   = PORT_W'(i);
        gnt_we_c    = we[i];
        gnt_size_c  = size[2*i +: 2];
        gnt_addr_c  = addr_i[ADDR_W*i +: ADDR_W];
        gnt_wdata_c = wdata_i[32*i +: 32];
      end
    end
  end

  // Index of the final byte of the access
  always_comb begin
    gnt_last_c = 2'd3;
    case (gnt_size_c)
      2'd0:    gnt_last_c = 2'd0;
      2'd1:    gnt_last_c = 2'd1;
      default: gnt_last_c = 2'd3;
    endcase
  end

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  // Half needs addr[0]=0, word needs addr[1:0]=0
  always_comb begin
    misalign_c = 1'b0;
    case (gnt_size_c)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = gnt_addr_c[0];
      default: misalign_c = |gnt_addr_c[1:0];
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  assign nxt_byte_c = byte_q + 2'd1;

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    last_d      = last_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    cyc_d       = cyc_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          port_d  = gnt_idx_c;
          we_d    = gnt_we_c;
          last_d  = gnt_last_c;
          base_d  = gnt_addr_c;
          wdata_d = gnt_wdata_c;
          byte_d  = 2'd0;
          cyc_d   = '0;
          rdata_d = '0;
          if (misalign_c) begin
            // Complete at once without touching memory
            state_d           = DONE;
            done_d[gnt_idx_c] = 1'b1;
            err_d[gnt_idx_c]  = 1'b1;
            mem_wr_d          = 1'b0;
          end else begin
            // First beat presents byte 0 right away
            state_d     = BEAT;
            mem_wr_d    = gnt_we_c;
            mem_addr_d  = gnt_addr_c;
            mem_wdata_d = gnt_wdata_c[7:0];
          end
        end
      end

      BEAT: begin
        if (!we_q && cancel[port_q]) begin
          // Abort load: no done, bus goes quiet
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (!we_q) begin
            rdata_d[8*byte_q +: 8] = mem_rdata;
          end
          if (byte_q == last_q) begin
            state_d        = DONE;
            done_d[port_q] = 1'b1;
            mem_wr_d       = 1'b0;
          end else begin
            byte_d      = nxt_byte_c;
            mem_addr_d  = base_q + ADDR_W'(nxt_byte_c);
            mem_wdata_d = wdata_q[8*nxt_byte_c +: 8];
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset overrides every other event
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= '0;
      we_q        <= 1'b0;
      last_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      byte_q      <= 2'd0;
      cyc_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      we_q        <= we_d;
      last_q      <= last_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      cyc_q       <= cyc_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata_o   = rdata_q;
  assign busy      = busy_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: directed vector table, hand-written
// multi-cycle sequences (priority, cancel, reset mid-store) and randomized
// transactions checked against a byte-array memory model.
module tb_mem_port_ctrl;

  localparam int unsigned NP = 2;
  localparam int unsigned BC = 2;
  localparam int unsigned AW = 32;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req, we, cancel;
  logic [2*NP-1:0]   size;
  logic [AW*NP-1:0]  addr_i;
  logic [32*NP-1:0]  wdata_i;
  logic [NP-1:0]     done, err;
  logic [31:0]       rdata_o;
  logic              busy, mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  mem_port_ctrl #(.NUM_PORTS(NP), .BEAT_CYC(BC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr_i(addr_i),
    .wdata_i(wdata_i), .cancel(cancel), .done(done), .err(err),
    .rdata_o(rdata_o), .busy(busy), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT and the reference copy kept by the model
  logic [7:0] dmem    [0:4095];
  logic [7:0] ref_mem [0:4095];
  assign mem_rdata = dmem[mem_addr[11:0]];
  always @(posedge clk) if (!rst && mem_wr) dmem[mem_addr[11:0]] <= mem_wdata;

  // Per-cycle bus activity log
  logic [39:0] wr_log [$];
  logic [31:0] rd_log [$];
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) wr_log.push_back({mem_addr, mem_wdata});
      else if (busy && done == '0) rd_log.push_back(mem_addr);
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] s, input logic [31:0] a);
    if (!ALIGN_EN) return 1'b0;
    if (s == 2'd1) return a[0];
    if (s >= 2'd2) return (a[1:0] != 2'd0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] ai;
    r = '0;
    for (int i = 0; i < nbytes(s); i++) begin
      ai = a + 32'(i);
      r[8*i +: 8] = ref_mem[ai[11:0]];
    end
    return r;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  // One complete transaction with full checking against the model
  task automatic run_txn(input int p, input bit w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [1:0] cm,
                         input string name);
    bit          mis;
    int          n, exp_lat, lat, bad;
    bit          got;
    logic [39:0] exp_wr [$];
    logic [31:0] exp_rdl [$];
    logic [31:0] ai;
    wait_idle();
    mis = misaligned(s, a);
    n = nbytes(s);
    exp_lat = mis ? 1 : 1 + n * int'(BC);
    if (!mis) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        for (int c = 0; c < int'(BC); c++) begin
          if (w) exp_wr.push_back({ai, wd[8*i +: 8]});
          else   exp_rdl.push_back(ai);
        end
      end
    end
    wr_log.delete();
    rd_log.delete();
    req[p] = 1'b1;
    we[p] = w;
    size[2*p +: 2] = s;
    addr_i[32*p +: 32] = a;
    wdata_i[32*p +: 32] = wd;
    cancel = cm;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done != '0) got = 1'b1;
    end
    check($sformatf("%s.latency", name), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.done", name), 64'(done), 64'(2'b01 << p));
    check($sformatf("%s.err", name), 64'(err), mis ? 64'(2'b01 << p) : 64'd0);
    check($sformatf("%s.rdata", name), 64'(rdata_o), (w || mis) ? 64'd0 : 64'(exp_rd));
    req[p] = 1'b0;
    cancel = '0;
    if (!mis && w) begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        ref_mem[ai[11:0]] = wd[8*i +: 8];
      end
    end
    bad = 0;
    if (wr_log.size() != exp_wr.size()) bad++;
    else foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) bad++;
    check($sformatf("%s.wr_bus", name), 64'(bad), 64'd0);
    bad = 0;
    if (rd_log.size() != exp_rdl.size()) bad++;
    else foreach (exp_rdl[i]) if (rd_log[i] !== exp_rdl[i]) bad++;
    check($sformatf("%s.rd_bus", name), 64'(bad), 64'd0);
    @(negedge clk);
    check($sformatf("%s.done_pulse", name), 64'(done), 64'd0);
    check($sformatf("%s.idle_after", name), 64'(busy), 64'd0);
  endtask

  typedef struct {
    int          port;
    bit          w;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [1:0]  cm;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vt [10];
    int   lat, seen;
    logic [31:0] e0, e1, ra, wdr;
    logic [1:0]  sr, cmr;
    int          pr;
    bit          wr;

    vt[0] = '{1, 1'b0, 2'd2, 32'h100, 32'h0,        32'h44332211, 2'b00};
    vt[1] = '{0, 1'b1, 2'd1, 32'h020, 32'hAABBCCDD, 32'h0,        2'b00};
    vt[2] = '{0, 1'b0, 2'd2, 32'h102, 32'h0,        32'h66554433, 2'b00};
    vt[3] = '{1, 1'b0, 2'd0, 32'h103, 32'h0,        32'h00000044, 2'b00};
    vt[4] = '{0, 1'b0, 2'd1, 32'h101, 32'h0,        32'h00003322, 2'b00};
    vt[5] = '{1, 1'b1, 2'd2, 32'h104, 32'h01020304, 32'h0,        2'b00};
    vt[6] = '{0, 1'b0, 2'd2, 32'h104, 32'h0,        32'h01020304, 2'b10};
    vt[7] = '{1, 1'b1, 2'd0, 32'h105, 32'h000000EE, 32'h0,        2'b10};
    vt[8] = '{0, 1'b0, 2'd3, 32'h104, 32'h0,        32'h0102EE04, 2'b00};
    vt[9] = '{0, 1'b0, 2'd1, 32'h106, 32'h0,        32'h00000102, 2'b00};

    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 8'(i * 13 + 7);
      ref_mem[i] = 8'(i * 13 + 7);
    end
    dmem[12'h100] = 8'h11; dmem[12'h101] = 8'h22; dmem[12'h102] = 8'h33;
    dmem[12'h103] = 8'h44; dmem[12'h104] = 8'h55; dmem[12'h105] = 8'h66;
    for (int i = 12'h100; i <= 12'h105; i++) ref_mem[i] = dmem[i];

    rst = 1'b1; req = '0; we = '0; cancel = '0; size = '0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.done", 64'(done), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.mem_wr", 64'(mem_wr), 64'd0);
    check("rst.mem_addr", 64'(mem_addr), 64'd0);
    check("rst.mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst.rdata", 64'(rdata_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_txn(vt[i].port, vt[i].w, vt[i].s, vt[i].a, vt[i].wd, vt[i].exp, vt[i].cm,
              $sformatf("vec%0d", i));

    // Simultaneous requests: port 0 first, one idle cycle, then port 1
    wait_idle();
    e0 = model_load(2'd0, 32'h100);
    e1 = model_load(2'd2, 32'h100);
    req = 2'b11; we = 2'b00; size = {2'd2, 2'd0};
    addr_i = {32'h100, 32'h100};
    lat = 0;
    while (done == '0 && lat < 64) begin @(posedge clk); lat++; @(negedge clk); end
    check("prio.p0_latency", 64'(lat), 64'(1 + BC));
    check("prio.p0_done", 64'(done), 64'b01);
    check("prio.p0_rdata", 64'(rdata_o), 64'(e0));
    req[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("prio.gap_busy", 64'(busy), 64'd0);
    lat = 0;
    while (done == '0 && lat < 64) begin @(posedge clk); lat++; @(negedge clk); end
    check("prio.p1_latency", 64'(lat), 64'(1 + 4 * BC));
    check("prio.p1_done", 64'(done), 64'b10);
    check("prio.p1_rdata", 64'(rdata_o), 64'(e1));
    req = '0;

    // Cancel a word load during its second beat
    wait_idle();
    rd_log.delete();
    req[1] = 1'b1; we[1] = 1'b0; size[3:2] = 2'd2; addr_i[63:32] = 32'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cancel[1] = 1'b1;
    req[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("cancel.busy", 64'(busy), 64'd0);
    check("cancel.done", 64'(done), 64'd0);
    cancel = '0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (done != '0 || busy) seen++; end
    check("cancel.quiet", 64'(seen), 64'd0);
    check("cancel.reads", 64'(rd_log.size()), 64'd3);

    // Reset during the third beat of a word store
    wait_idle();
    req[0] = 1'b1; we[0] = 1'b1; size[1:0] = 2'd2;
    addr_i[31:0] = 32'h200; wdata_i[31:0] = 32'hCAFEF00D;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rststore.mem_addr", 64'(mem_addr), 64'h202);
    check("rststore.mem_wdata", 64'(mem_wdata), 64'hFE);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rststore.mem_wr", 64'(mem_wr), 64'd0);
    check("rststore.busy", 64'(busy), 64'd0);
    check("rststore.done", 64'(done), 64'd0);
    rst = 1'b0;
    req = '0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done != '0) seen++; end
    check("rststore.no_done", 64'(seen), 64'd0);
    ref_mem[12'h200] = dmem[12'h200];
    ref_mem[12'h201] = dmem[12'h201];

    // Randomized transactions against the model
    for (int k = 0; k < 40; k++) begin
      pr = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else ra = 32'h300 + 32'($urandom_range(0, 63));
      wdr = $urandom;
      cmr = 2'($urandom_range(0, 3));
      if (!wr) cmr[pr] = 1'b0;
      run_txn(pr, wr, sr, ra, wdr, model_load(sr, ra), cmr, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester ports (legal 1..4); port 0 is highest priority.
REQ-002 SHALL have parameter BEAT_CYC, default 2, cycles per byte beat on the memory bus (legal 1..4).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req  in  NUM_PORTS  per-port request level, held until that port's done.
REQ-008 we  in  NUM_PORTS  per-port 1=store, 0=load.
REQ-009 size  in  2*NUM_PORTS  per-port access size: 0=byte, 1=half, 2 or 3=word.
REQ-010 addr_i  in  ADDR_W*NUM_PORTS  per-port byte address.
REQ-011 wdata_i  in  32*NUM_PORTS  per-port store data, little-endian.
REQ-012 cancel  in  NUM_PORTS  per-port abort of an in-flight load.
REQ-013 done  out  NUM_PORTS  one-cycle completion pulse.
REQ-014 err  out  NUM_PORTS  one-cycle misalignment pulse, coincident with done.
REQ-015 rdata_o  out  32  load result, zero-extended; valid only while any done bit is high.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 mem_wr  out  1  memory write strobe.
REQ-018 mem_addr  out  ADDR_W  memory byte address.
REQ-019 mem_wdata  out  8  memory write byte.
REQ-020 mem_rdata  in  8  memory read byte.

Function
REQ-021 SHALL implement the states IDLE, BEAT and DONE.
REQ-022 IDLE: SHALL grant the lowest-index port with req=1 and latch its we, size, addr and wdata; the next state SHALL be BEAT. With no req, SHALL remain in IDLE.
REQ-023 Byte count: size 0 -> 1, size 1 -> 2, size 2 or 3 -> 4.
REQ-024 BEAT: each byte SHALL take exactly BEAT_CYC cycles; mem_addr, mem_wdata and mem_wr SHALL be stable for the whole beat; mem_addr SHALL be base+i for byte i, wrapping modulo 2^ADDR_W.
REQ-025 Loads: mem_wr SHALL be 0; mem_rdata SHALL be sampled on the last cycle of each beat into rdata_o byte i; unused upper bytes SHALL be 0.
REQ-026 Stores: mem_wr SHALL be 1 for all beats; mem_wdata SHALL be wdata byte i; rdata_o SHALL be 0.
REQ-027 After the last beat: SHALL enter DONE for exactly one cycle with done[granted]=1, then return to IDLE.
REQ-028 Latency: req sampled at edge 0 -> done high in cycle 1+N*BEAT_CYC.
REQ-029 Arbitration SHALL occur only in IDLE, so back-to-back grants are separated by one IDLE cycle; a request that stays high is not re-granted before IDLE.
REQ-030 cancel[g] in BEAT for a load: at the next edge SHALL go to IDLE with no done pulse and no further memory access.
REQ-031 cancel SHALL be ignored during stores, in DONE, and for non-granted ports.
REQ-032 Requests from other ports during BEAT or DONE SHALL wait, with no loss or reordering by priority.

Reset
REQ-033 rst=1 at any edge SHALL force IDLE, done=0, err=0, busy=0, mem_wr=0, mem_addr=0, mem_wdata=0 and rdata_o=0, overriding every other event.
REQ-034 A transfer aborted by reset SHALL never produce done; a store may be partially written.

Configuration
REQ-035 With MEM_CTRL_ALIGN_CHECK_EN defined, a misaligned request SHALL go directly from IDLE to DONE, with done=1, err=1, rdata_o=0 and no memory access.
REQ-036 Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-037 Without MEM_CTRL_ALIGN_CHECK_EN, err SHALL be constant 0, and misaligned requests SHALL proceed byte-serially per REQ-024.

Verification
REQ-038 Word load: port1, addr 0x100, memory bytes 11 22 33 44, BEAT_CYC=2 -> done[1] in cycle 9, rdata_o=0x44332211, mem_wr never 1.
REQ-039 Half store: port0, addr 0x20, wdata 0xAABBCCDD -> mem_wr high 4 cycles; bytes DD@0x20 then CC@0x21; done[0] in cycle 5; no access to 0x22.
REQ-040 Simultaneous req: port0 byte load and port1 word load at the same edge -> port0 done first, one IDLE cycle, then port1 served and done.
REQ-041 Cancel: port1 word load with cancel[1] pulsed in beat 2 -> IDLE next edge, no done[1], busy=0.
REQ-042 Reset mid-store: rst during beat 3 of a word store -> next cycle mem_wr=0, busy=0, no done.
REQ-043 With MEM_CTRL_ALIGN_CHECK_EN: word load at 0x102 -> done and err in cycle 1, no mem access; without the macro -> bytes 0x102..0x105 read.
